// File: rtl/mtsp_if_queue_pkg.sv
// Shared constants for the MTSP instruction-fetch queue: bundle geometry,
// the bubble encoding and the unit-instruction slot layout inside a bundle.
package mtsp_if_queue_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 16;
    localparam int unsigned BUNDLE_W         = 128;
    localparam int unsigned UINST_W          = 32;

    localparam logic [BUNDLE_W-1:0] UINST_BUBBLE = '1;

    // Bundle layout, MSB first: {p0_m, p0_s, p1_m, p1_s}
    localparam int unsigned P0_M_LSB = 96;
    localparam int unsigned P0_S_LSB = 64;
    localparam int unsigned P1_M_LSB = 32;
    localparam int unsigned P1_S_LSB = 0;

    typedef enum logic [1:0] {
        SLOT_P0_M = 2'd0,
        SLOT_P0_S = 2'd1,
        SLOT_P1_M = 2'd2,
        SLOT_P1_S = 2'd3
    } uinst_slot_e;

    function automatic logic [UINST_W-1:0] uinst_slot(
        input logic [BUNDLE_W-1:0] bundle,
        input uinst_slot_e         slot
    );
        logic [UINST_W-1:0] word;
        case (slot)
            SLOT_P0_M: word = bundle[P0_M_LSB +: UINST_W];
            SLOT_P0_S: word = bundle[P0_S_LSB +: UINST_W];
            SLOT_P1_M: word = bundle[P1_M_LSB +: UINST_W];
            default:   word = bundle[P1_S_LSB +: UINST_W];
        endcase
        return word;
    endfunction

    function automatic logic is_bubble(input logic [BUNDLE_W-1:0] bundle);
        return bundle == UINST_BUBBLE;
    endfunction

endpackage

// File: rtl/mtsp_if_fifo.sv
// Synchronous FIFO holding fetched {pc, bundle} entries; push and pop may
// coincide even when full, and clear empties it in one cycle.
module mtsp_if_fifo #(
    parameter int unsigned WIDTH = 144,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH + 1)-1:0]   count,
    output logic                           empty
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && full && !pop));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !clear && empty));

endmodule

// File: rtl/mtsp_if_queue.sv
// MTSP instruction-fetch stage: credit-limited bundle fetch, response
// buffering with PC tagging, redirect flush and one-bundle-per-cycle issue.
module mtsp_if_queue
    import mtsp_if_queue_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = PC_WIDTH_DEFAULT,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                RUN,
    input  logic                STALL,
    input  logic                REDIRECT_EN,
    input  logic [PC_WIDTH-1:0] REDIRECT_PC,
    output logic                IMEM_REQ_VALID,
    input  logic                IMEM_REQ_READY,
    output logic [PC_WIDTH-1:0] IMEM_REQ_ADDR,
    input  logic                IMEM_RSP_VALID,
    input  logic [BUNDLE_W-1:0] IMEM_RSP_DATA,
    output logic [PC_WIDTH-1:0] PC_OUT,
    output logic [BUNDLE_W-1:0] UINSTx4_OUT
);
    localparam int unsigned    CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned    ENTRY_W    = PC_WIDTH + BUNDLE_W;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    logic [PC_WIDTH-1:0] fpc;
    logic [PC_WIDTH-1:0] rsp_pc;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    outstanding_next;
    logic [CNT_W-1:0]    discard;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [CNT_W:0]      credit_used;
    logic                req_hs;
    logic                rsp_keep;
    logic                pop;

    // Buffered plus in-flight fetches never exceed DEPTH, so a push always fits.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign IMEM_REQ_VALID = nRST & RUN & ~REDIRECT_EN & (credit_used < CREDIT_MAX);
    assign IMEM_REQ_ADDR  = fpc;
    assign req_hs         = IMEM_REQ_VALID & IMEM_REQ_READY;

    assign rsp_keep = IMEM_RSP_VALID & ~REDIRECT_EN & (discard == '0);
    assign pop      = ~fifo_empty & ~STALL & ~REDIRECT_EN;

    always_comb begin
        outstanding_next = outstanding;
        if (req_hs && !IMEM_RSP_VALID) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (!req_hs && IMEM_RSP_VALID) begin
            outstanding_next = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fpc         <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (REDIRECT_EN) begin
                // Every fetch still in flight after this cycle belongs to the old path.
                fpc     <= REDIRECT_PC;
                rsp_pc  <= REDIRECT_PC;
                discard <= outstanding_next;
            end else begin
                if (req_hs) fpc <= fpc + PC_WIDTH'(1);
                if (IMEM_RSP_VALID) begin
                    if (discard != '0) discard <= discard - CNT_W'(1);
                    else               rsp_pc  <= rsp_pc + PC_WIDTH'(1);
                end
            end
        end
    end

    mtsp_if_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .clear     (REDIRECT_EN),
        .push      (rsp_keep),
        .push_data ({rsp_pc, IMEM_RSP_DATA}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            PC_OUT      <= '0;
            UINSTx4_OUT <= UINST_BUBBLE;
        end else if (pop) begin
            PC_OUT      <= fifo_head[ENTRY_W-1 -: PC_WIDTH];
            UINSTx4_OUT <= fifo_head[BUNDLE_W-1:0];
        end else begin
            UINSTx4_OUT <= UINST_BUBBLE;
        end
    end

    a_rsp_expected: assert property (@(posedge CLK) disable iff (!nRST)
        IMEM_RSP_VALID |-> (outstanding != '0));

    a_credit_bound: assert property (@(posedge CLK) disable iff (!nRST)
        credit_used <= CREDIT_MAX);

    a_discard_bound: assert property (@(posedge CLK) disable iff (!nRST)
        discard <= outstanding);

endmodule
